// File: rtl/judge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : judge_pkg                                                  |
// | Purpose : Shared state encodings and default widths for the          |
// |           per-column note judge.                                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package judge_pkg;

    // Default datapath sizing
    localparam int DEF_SCORE_W  = 10;
    localparam int DEF_COMBO_W  = 7;
    localparam int DEF_BONUS_AT = 10;

    // Judge FSM encoding
    localparam int               STATE_W   = 2;
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_ARMED  = 2'd1;
    localparam logic [STATE_W-1:0] ST_JUDGED = 2'd2;

endpackage : judge_pkg
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : key_edge                                                   |
// | Purpose : Rising-edge detector for a pre-synchronised key input.     |
// |           The history flop resets high so a key already held when    |
// |           reset releases is not taken as a fresh press.              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module key_edge (
    input  logic CLOCK,
    input  logic RESET,
    input  logic KEY,
    output logic press
);

    logic key_q;

    // Remember last cycle's key level; treat reset as "key was held"
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            key_q <= 1'b1;
        end else begin
            key_q <= KEY;
        end
    end

    assign press = KEY & ~key_q;

endmodule : key_edge
`default_nettype wire

// File: rtl/column_judge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : column_judge                                               |
// | Purpose : Judges key presses against one column's target-row light,  |
// |           producing hit/miss pulses, a light-clear pulse, and        |
// |           saturating score / combo / max-combo counters.             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module column_judge
    import judge_pkg::*;
#(
    parameter int SCORE_W  = DEF_SCORE_W,
    parameter int COMBO_W  = DEF_COMBO_W,
    parameter int BONUS_AT = DEF_BONUS_AT
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               KEY,
    input  logic               TARGETON,
    output logic               GOTCHA,
    output logic               HIT,
    output logic               MISS,
    output logic [SCORE_W-1:0] SCORE,
    output logic [COMBO_W-1:0] COMBO,
    output logic [COMBO_W-1:0] MAXCOMBO
);

    localparam logic [31:0] BONUS_U = 32'(BONUS_AT);

    logic               press;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic               hit_evt;
    logic               miss_evt;
    logic               bonus;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic [COMBO_W-1:0] combo_next;
    logic [COMBO_W-1:0] maxcombo_next;

    key_edge u_key_edge (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .KEY   (KEY),
        .press (press)
    );

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a note arms on the light, is judged once, and the
    // light must drop before the next note can arm again
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (TARGETON) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Light going out wins over a coincident press: that is a miss
                if (!TARGETON) begin
                    state_next = ST_IDLE;
                end else if (press) begin
                    state_next = ST_JUDGED;
                end
            end
            ST_JUDGED: begin
                if (!TARGETON) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output/next-value logic: events and saturating counter updates
    always_comb begin
        hit_evt  = (state == ST_ARMED) && TARGETON && press;
        miss_evt = (state == ST_ARMED) && !TARGETON;

        // Bonus decided on the combo count before this hit is added
        bonus     = ({{(32-COMBO_W){1'b0}}, COMBO} >= BONUS_U);
        score_sum = {1'b0, SCORE} + (bonus ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));

        score_next    = SCORE;
        combo_next    = COMBO;
        maxcombo_next = MAXCOMBO;

        if (hit_evt) begin
            score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
            combo_next = (COMBO == {COMBO_W{1'b1}}) ? COMBO : COMBO + 1'b1;
        end else if (miss_evt) begin
            combo_next = '0;
        end

        if (combo_next > MAXCOMBO) begin
            maxcombo_next = combo_next;
        end
    end

    // Output registers; reset clears everything including any pending pulse
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            GOTCHA   <= 1'b0;
            HIT      <= 1'b0;
            MISS     <= 1'b0;
            SCORE    <= '0;
            COMBO    <= '0;
            MAXCOMBO <= '0;
        end else begin
            GOTCHA   <= hit_evt;
            HIT      <= hit_evt;
            MISS     <= miss_evt;
            SCORE    <= score_next;
            COMBO    <= combo_next;
            MAXCOMBO <= maxcombo_next;
        end
    end

endmodule : column_judge
`default_nettype wire

// File: tb/tb_column_judge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_column_judge                                            |
// | Purpose : Directed self-checking bench for column_judge: a vector    |
// |           table plus hand-written multi-cycle sequences. A second    |
// |           instance with a 3-bit score shares the stimulus.           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_column_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tgt = 1'b0;
    logic       key = 1'b0;

    logic       gotcha, hit, miss;
    logic [9:0] score;
    logic [6:0] combo, maxcombo;

    logic       s_gotcha, s_hit, s_miss;
    logic [2:0] s_score;
    logic [6:0] s_combo, s_maxcombo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    column_judge dut (
        .CLOCK    (clk),
        .RESET    (rst),
        .KEY      (key),
        .TARGETON (tgt),
        .GOTCHA   (gotcha),
        .HIT      (hit),
        .MISS     (miss),
        .SCORE    (score),
        .COMBO    (combo),
        .MAXCOMBO (maxcombo)
    );

    column_judge #(.SCORE_W(3)) dut_small (
        .CLOCK    (clk),
        .RESET    (rst),
        .KEY      (key),
        .TARGETON (tgt),
        .GOTCHA   (s_gotcha),
        .HIT      (s_hit),
        .MISS     (s_miss),
        .SCORE    (s_score),
        .COMBO    (s_combo),
        .MAXCOMBO (s_maxcombo)
    );

    typedef struct packed {
        logic       r;
        logic       t;
        logic       k;
        logic       g;
        logic       h;
        logic       m;
        logic [9:0] sc;
        logic [6:0] co;
        logic [6:0] mx;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Drive inputs away from the active edge, then sample just after it
    task automatic step(input logic r, input logic t, input logic k);
        @(negedge clk);
        rst = r;
        tgt = t;
        key = k;
        @(posedge clk);
        #1;
    endtask

    // One complete note: arm, press, release light
    task automatic hit_note(input int i, input int exp_sc, input int exp_co,
                            input int exp_mx, input int exp_ssc);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk($sformatf("note%0d_hit", i), int'(hit), 1);
        chk($sformatf("note%0d_gotcha", i), int'(gotcha), 1);
        chk($sformatf("note%0d_score", i), int'(score), exp_sc);
        chk($sformatf("note%0d_combo", i), int'(combo), exp_co);
        chk($sformatf("note%0d_max", i), int'(maxcombo), exp_mx);
        chk($sformatf("note%0d_small_score", i), int'(s_score), exp_ssc);
        step(1'b0, 1'b0, 1'b0);
        chk($sformatf("note%0d_hit_clear", i), int'(hit), 0);
    endtask

    initial begin
        //              r  t  k  g  h  m  score combo max
        vecs[0]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 10'd0, 7'd0, 7'd0}; // reset
        vecs[1]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 10'd0, 7'd0, 7'd0};
        vecs[2]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 10'd0, 7'd0, 7'd0}; // arm
        vecs[3]  = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0, 10'd1, 7'd1, 7'd1}; // hit
        vecs[4]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 10'd1, 7'd1, 7'd1}; // held
        vecs[5]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 10'd1, 7'd1, 7'd1};
        vecs[6]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 10'd1, 7'd1, 7'd1}; // arm
        vecs[7]  = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 10'd1, 7'd1, 7'd1};
        vecs[8]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1, 10'd1, 7'd0, 7'd1}; // miss
        vecs[9]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 10'd1, 7'd0, 7'd1}; // idle press
        vecs[10] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 10'd1, 7'd0, 7'd1}; // arm
        vecs[11] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1, 10'd1, 7'd0, 7'd1}; // press as light drops
        vecs[12] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 10'd1, 7'd0, 7'd1};
        vecs[13] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 10'd1, 7'd0, 7'd1}; // press on arm edge
        vecs[14] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 10'd1, 7'd0, 7'd1}; // held: no press
        vecs[15] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 10'd1, 7'd0, 7'd1};
        vecs[16] = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0, 10'd2, 7'd1, 7'd1}; // hit
        vecs[17] = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0, 10'd0, 7'd0, 7'd0}; // reset, key held
        vecs[18] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 10'd0, 7'd0, 7'd0}; // arm, no press
        vecs[19] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 10'd0, 7'd0, 7'd0};
        vecs[20] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 10'd0, 7'd0, 7'd0}; // key falls
        vecs[21] = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0, 10'd1, 7'd1, 7'd1}; // re-press hits
        vecs[22] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 10'd1, 7'd1, 7'd1};
        vecs[23] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 10'd1, 7'd1, 7'd1}; // arm
        vecs[24] = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0, 10'd0, 7'd0, 7'd0}; // reset beats hit

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].r, vecs[i].t, vecs[i].k);
            chk($sformatf("v%0d_gotcha", i), int'(gotcha), int'(vecs[i].g));
            chk($sformatf("v%0d_hit", i), int'(hit), int'(vecs[i].h));
            chk($sformatf("v%0d_miss", i), int'(miss), int'(vecs[i].m));
            chk($sformatf("v%0d_score", i), int'(score), int'(vecs[i].sc));
            chk($sformatf("v%0d_combo", i), int'(combo), int'(vecs[i].co));
            chk($sformatf("v%0d_max", i), int'(maxcombo), int'(vecs[i].mx));
            chk($sformatf("v%0d_small_score", i), int'(s_score), int'(vecs[i].sc));
        end

        // Hit timeline: light from cycle 5, key from cycle 7 -> pulse in cycle 8
        for (int c = 0; c < 13; c++) begin
            step(c == 0, c >= 5, c >= 7);
            chk($sformatf("tl_hit_c%0d", c + 1), int'(hit), int'(c + 1 == 8));
            chk($sformatf("tl_gotcha_c%0d", c + 1), int'(gotcha), int'(c + 1 == 8));
            chk($sformatf("tl_miss_c%0d", c + 1), int'(miss), 0);
        end
        chk("tl_score", int'(score), 1);
        chk("tl_combo", int'(combo), 1);
        chk("tl_max", int'(maxcombo), 1);

        // Miss timeline: light in cycles 5-9, no key -> miss pulse in cycle 11
        for (int c = 0; c < 14; c++) begin
            step(c == 0, (c >= 5) && (c <= 9), 1'b0);
            chk($sformatf("tm_miss_c%0d", c + 1), int'(miss), int'(c + 1 == 11));
            chk($sformatf("tm_hit_c%0d", c + 1), int'(hit), 0);
        end
        chk("tm_score", int'(score), 0);
        chk("tm_combo", int'(combo), 0);

        // Twelve hits from reset: last two earn the bonus; small score saturates at 7
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        begin
            int exp_sc;
            exp_sc = 0;
            for (int n = 1; n <= 12; n++) begin
                exp_sc += (n - 1 >= 10) ? 2 : 1;
                hit_note(n, exp_sc, n, n, (exp_sc > 7) ? 7 : exp_sc);
            end
        end
        chk("streak_score", int'(score), 14);
        chk("streak_small_combo", int'(s_combo), 12);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("streak_miss", int'(miss), 1);
        chk("streak_miss_combo", int'(combo), 0);
        chk("streak_miss_max", int'(maxcombo), 12);
        chk("streak_miss_score", int'(score), 14);
        chk("streak_small_sat", int'(s_score), 7);

        // Reset while armed with a press pending: everything clears next cycle
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_arm_hit", int'(hit), 0);
        chk("rst_arm_gotcha", int'(gotcha), 0);
        chk("rst_arm_score", int'(score), 0);
        chk("rst_arm_max", int'(maxcombo), 0);
        chk("rst_arm_small_score", int'(s_score), 0);
        chk("rst_arm_small_hit", int'(s_hit), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_column_judge
`default_nettype wire
